// File: rtl/traffic_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_sequencer
//
// Two-road intersection controller with a pedestrian crossing phase.
// Main road rests green until the side road or a pedestrian needs service;
// the pedestrian phase takes precedence over the side-road green when both
// are waiting. All outputs are decoded from registered state (Moore).
//
// Parameters
//   GREEN_CYC  : minimum main green / exact side green dwell (1..255)
//   YELLOW_CYC : yellow dwell (1..255)
//   ALLRED_CYC : all-red clearance dwell (1..255)
//   WALK_CYC   : pedestrian walk dwell (1..255)
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst        : synchronous active-high reset
//   side_req   : side-road vehicle sensor (level)
//   ped_req    : pedestrian button; any high cycle outside WALK is latched
//   main_light : main lamp, RED=000 GREEN=001 YELLOW=010
//   side_light : side lamp, same encoding
//   walk       : pedestrian walk indication
//   ped_ack    : single-cycle pulse on the first cycle of WALK
// ---------------------------------------------------------------------------
module traffic_sequencer #(
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 3,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned WALK_CYC   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_ack
);

    localparam logic [2:0] LAMP_RED    = 3'b000;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;

    // Terminal counts: the last cycle spent in each phase.
    localparam logic [7:0] GREEN_LAST  = 8'(GREEN_CYC - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_CYC - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_CYC - 1);
    localparam logic [7:0] WALK_LAST   = 8'(WALK_CYC - 1);

    typedef enum logic [2:0] {
        M_GRN = 3'd0,
        M_YEL = 3'd1,
        AR_A  = 3'd2,
        WALK  = 3'd3,
        S_GRN = 3'd4,
        S_YEL = 3'd5,
        AR_B  = 3'd6
    } state_e;

    state_e     state_q,       state_d;
    logic [7:0] cnt_q,         cnt_d;
    logic       ped_pending_q, ped_pending_d;
    logic       svc;

    // -----------------------------------------------------------------------
    // Next-state, dwell counter and pedestrian latch
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ped_pending_d = ped_pending_q;
        svc           = ped_pending_q | ped_req | side_req;

        case (state_q)
            M_GRN: begin
                if ((cnt_q >= GREEN_LAST) && svc) begin
                    state_d = M_YEL;
                end
            end
            M_YEL: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d = AR_A;
                end
            end
            AR_A: begin
                if (cnt_q == ALLRED_LAST) begin
                    state_d = ped_pending_q ? WALK : S_GRN;
                end
            end
            WALK: begin
                // Always return through AR_B to main green; side waits for
                // the next main-green exit.
                if (cnt_q == WALK_LAST) begin
                    state_d = AR_B;
                end
            end
            S_GRN: begin
                if (cnt_q == GREEN_LAST) begin
                    state_d = S_YEL;
                end
            end
            S_YEL: begin
                if (cnt_q == YELLOW_LAST) begin
                    state_d = AR_B;
                end
            end
            AR_B: begin
                if (cnt_q == ALLRED_LAST) begin
                    state_d = M_GRN;
                end
            end
            default: begin
                // Unused encoding: recover to main green.
                state_d = M_GRN;
            end
        endcase

        // Counter restarts on every state change; main green holds at its
        // terminal count so it can rest there indefinitely.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == M_GRN) && (cnt_q >= GREEN_LAST)) begin
            cnt_d = GREEN_LAST;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        // Entering WALK serves the request; clearing wins over a press that
        // lands on that same cycle. Presses during WALK are ignored.
        if ((state_d == WALK) && (state_q != WALK)) begin
            ped_pending_d = 1'b0;
        end else if (ped_req && (state_q != WALK)) begin
            ped_pending_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= M_GRN;
            cnt_q         <= '0;
            ped_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
        end
    end

    // -----------------------------------------------------------------------
    // Moore output decode
    // -----------------------------------------------------------------------
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
        ped_ack    = 1'b0;

        case (state_q)
            M_GRN: main_light = LAMP_GREEN;
            M_YEL: main_light = LAMP_YELLOW;
            S_GRN: side_light = LAMP_GREEN;
            S_YEL: side_light = LAMP_YELLOW;
            WALK: begin
                walk    = 1'b1;
                // cnt is zero only on the entry cycle of WALK.
                ped_ack = (cnt_q == 8'd0);
            end
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

endmodule
